// File: rtl/game_physics.sv
// Paddle/ball game logic, one update per renderer frame tick.
// Optional SCORE output enabled by defining GAME_PHYSICS_SCORE_EN.
`timescale 1ns/1ps
module game_physics #(
  parameter int PADDLE_LENGTH_PIXEL = 60,
  parameter int BALL_SIZE_PIXEL     = 8,
  parameter int BALL_SPEED          = 2,
  parameter int PADDLE_SPEED        = 4,
  parameter int LOST_FRAMES         = 60
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       FRAME_DONE,
  input  logic       BTN_LEFT,
  input  logic       BTN_RIGHT,
  input  logic       BTN_LAUNCH,
  output logic [9:0] PADDLE_X_PIXEL,
  output logic [9:0] BALL_X_PIXEL,
  output logic [9:0] BALL_Y_PIXEL,
  output logic [1:0] STATE
`ifdef GAME_PHYSICS_SCORE_EN
  ,
  output logic [7:0] SCORE
`endif
);

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    PLAY  = 2'd1,
    LOST  = 2'd2,
    BAD   = 2'd3
  } state_e;

  localparam int CW   = (LOST_FRAMES > 1) ? $clog2(LOST_FRAMES) : 1;
  localparam int PMAX = 792 - PADDLE_LENGTH_PIXEL;
  localparam int OFS  = (PADDLE_LENGTH_PIXEL - BALL_SIZE_PIXEL) / 2;

  localparam logic [9:0] P_RST = 10'd370;
  localparam logic [9:0] P_MIN = 10'd8;
  localparam logic [9:0] P_MAX = 10'(PMAX);
  localparam logic [9:0] Y_TOP = 10'd80;
  localparam logic [9:0] Y_PAD = 10'd576;
  localparam logic [9:0] Y_FLR = 10'd600;
  localparam logic [9:0] X_L   = 10'd8;
  localparam logic [9:0] X_R   = 10'd784;

  localparam logic signed [10:0] S_TOP = 11'sd80;
  localparam logic signed [10:0] S_PAD = 11'sd576;
  localparam logic signed [10:0] S_FLR = 11'sd600;
  localparam logic signed [10:0] S_XL  = 11'sd8;
  localparam logic signed [10:0] S_XR  = 11'sd784;
  localparam logic signed [10:0] HALF  = 11'(BALL_SIZE_PIXEL / 2);
  localparam logic signed [10:0] T1    = 11'(PADDLE_LENGTH_PIXEL / 3);
  localparam logic signed [10:0] T2    = 11'((2 * PADDLE_LENGTH_PIXEL) / 3);

  localparam logic signed [3:0] VP = 4'(BALL_SPEED);
  localparam logic signed [3:0] VN = -VP;

  state_e             st;
  logic signed [3:0]  dx, dy;
  logic [CW-1:0]      cnt;

  logic [9:0]         px_n;
  logic signed [10:0] nx, ny, ctr;
  logic [9:0]         bx_n, by_n;
  logic signed [3:0]  dx_n, dy_n;
  logic               hit, lose, wrap;

  assign STATE = st;
  assign wrap  = (cnt == CW'(LOST_FRAMES - 1));

  always_comb begin
    px_n = PADDLE_X_PIXEL;
    unique case ({BTN_LEFT, BTN_RIGHT})
      2'b10: px_n = (PADDLE_X_PIXEL < P_MIN + 10'(PADDLE_SPEED)) ?
                    P_MIN : PADDLE_X_PIXEL - 10'(PADDLE_SPEED);
      2'b01: px_n = (PADDLE_X_PIXEL > P_MAX - 10'(PADDLE_SPEED)) ?
                    P_MAX : PADDLE_X_PIXEL + 10'(PADDLE_SPEED);
      default: px_n = PADDLE_X_PIXEL;
    endcase
  end

  always_comb begin
    nx   = $signed({1'b0, BALL_X_PIXEL}) + {{7{dx[3]}}, dx};
    ny   = $signed({1'b0, BALL_Y_PIXEL}) + {{7{dy[3]}}, dy};
    ctr  = $signed({1'b0, BALL_X_PIXEL})
         - $signed({1'b0, PADDLE_X_PIXEL}) + HALF;
    hit  = !dy[3] && (BALL_Y_PIXEL <= Y_PAD) && (ny >= S_PAD)
        && ({1'b0, BALL_X_PIXEL} + 11'(BALL_SIZE_PIXEL) > {1'b0, PADDLE_X_PIXEL})
        && ({1'b0, BALL_X_PIXEL} < {1'b0, PADDLE_X_PIXEL} + 11'(PADDLE_LENGTH_PIXEL));
    bx_n = nx[9:0];
    dx_n = dx;
    by_n = ny[9:0];
    dy_n = dy;
    lose = 1'b0;
    if (nx < S_XL) begin
      bx_n = X_L;
      dx_n = VP;
    end else if (nx > S_XR) begin
      bx_n = X_R;
      dx_n = VN;
    end
    if (ny < S_TOP) begin
      by_n = Y_TOP;
      dy_n = VP;
    end else if (hit) begin
      // paddle thirds steer the ball; centre third keeps current heading
      by_n = Y_PAD;
      dy_n = VN;
      if (ctr < T1) dx_n = VN;
      else if (ctr >= T2) dx_n = VP;
    end else if (!dy[3] && ny >= S_FLR) begin
      by_n = Y_FLR;
      lose = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      st             <= SERVE;
      PADDLE_X_PIXEL <= P_RST;
      BALL_X_PIXEL   <= P_RST + 10'(OFS);
      BALL_Y_PIXEL   <= Y_PAD;
      dx             <= VP;
      dy             <= VN;
      cnt            <= '0;
    end else if (FRAME_DONE) begin
      PADDLE_X_PIXEL <= px_n;
      case (st)
        SERVE: begin
          BALL_X_PIXEL <= px_n + 10'(OFS);
          BALL_Y_PIXEL <= Y_PAD;
          if (BTN_LAUNCH) begin
            st <= PLAY;
            dx <= VP;
            dy <= VN;
          end
        end
        PLAY: begin
          BALL_X_PIXEL <= bx_n;
          BALL_Y_PIXEL <= by_n;
          dx           <= dx_n;
          dy           <= dy_n;
          if (lose) begin
            st  <= LOST;
            cnt <= '0;
          end
        end
        LOST: begin
          if (wrap) begin
            st           <= SERVE;
            BALL_X_PIXEL <= px_n + 10'(OFS);
            BALL_Y_PIXEL <= Y_PAD;
            cnt          <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          st           <= SERVE;
          BALL_X_PIXEL <= px_n + 10'(OFS);
          BALL_Y_PIXEL <= Y_PAD;
          cnt          <= '0;
        end
      endcase
    end
  end

`ifdef GAME_PHYSICS_SCORE_EN
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      SCORE <= 8'd0;
    end else if (FRAME_DONE) begin
      if (st == PLAY && hit && SCORE != 8'hff)
        SCORE <= SCORE + 8'd1;
      else if (st == LOST && wrap)
        SCORE <= 8'd0;
    end
  end
`endif

endmodule

// File: tb/tb_game_physics.sv
// Scoreboard bench for game_physics: stimulus pushes expected frame
// results, a monitor pops and compares on every frame tick.
`timescale 1ns/1ps
module tb_game_physics;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       FRAME_DONE = 1'b0;
  logic       BTN_LEFT = 1'b0;
  logic       BTN_RIGHT = 1'b0;
  logic       BTN_LAUNCH = 1'b0;
  logic [9:0] PADDLE_X_PIXEL;
  logic [9:0] BALL_X_PIXEL;
  logic [9:0] BALL_Y_PIXEL;
  logic [1:0] STATE;
`ifdef GAME_PHYSICS_SCORE_EN
  logic [7:0] SCORE;
`endif

  game_physics dut (
    .CLK            (CLK),
    .RESET_N        (RESET_N),
    .FRAME_DONE     (FRAME_DONE),
    .BTN_LEFT       (BTN_LEFT),
    .BTN_RIGHT      (BTN_RIGHT),
    .BTN_LAUNCH     (BTN_LAUNCH),
    .PADDLE_X_PIXEL (PADDLE_X_PIXEL),
    .BALL_X_PIXEL   (BALL_X_PIXEL),
    .BALL_Y_PIXEL   (BALL_Y_PIXEL),
    .STATE          (STATE)
`ifdef GAME_PHYSICS_SCORE_EN
    ,
    .SCORE          (SCORE)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int st;
    int px;
    int bx;
    int by;
    int sc;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  int m_st, m_px, m_bx, m_by, m_dx, m_dy, m_cnt, m_score;

  function automatic void chk(string name, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int dut_score();
`ifdef GAME_PHYSICS_SCORE_EN
    return int'(SCORE);
`else
    return 0;
`endif
  endfunction

  function automatic void model_reset();
    m_st = 0; m_px = 370; m_bx = 396; m_by = 576;
    m_dx = 2; m_dy = -2; m_cnt = 0; m_score = 0;
  endfunction

  function automatic void model_step(bit l, bit r, bit go);
    int p0, np, nx, ny, x, y, ndx, ndy, c;
    p0 = m_px;
    np = m_px;
    if (l && !r) np = (m_px - 4 < 8) ? 8 : m_px - 4;
    if (r && !l) np = (m_px + 4 > 732) ? 732 : m_px + 4;
    if (m_st == 0) begin
      m_bx = np + 26;
      m_by = 576;
      if (go) begin
        m_st = 1; m_dx = 2; m_dy = -2;
      end
    end else if (m_st == 1) begin
      nx = m_bx + m_dx; ny = m_by + m_dy;
      x = nx; y = ny; ndx = m_dx; ndy = m_dy;
      if (nx < 8) begin x = 8; ndx = 2; end
      else if (nx > 784) begin x = 784; ndx = -2; end
      if (ny < 80) begin
        y = 80; ndy = 2;
      end else if (m_dy > 0 && m_by <= 576 && ny >= 576 &&
                   m_bx + 8 > p0 && m_bx < p0 + 60) begin
        y = 576; ndy = -2;
        c = m_bx + 4 - p0;
        if (c < 20) ndx = -2;
        else if (c >= 40) ndx = 2;
        if (m_score < 255) m_score++;
      end else if (m_dy > 0 && ny >= 600) begin
        y = 600; m_st = 2; m_cnt = 0;
      end
      m_bx = x; m_by = y; m_dx = ndx; m_dy = ndy;
    end else begin
      if (m_cnt == 59) begin
        m_st = 0; m_bx = np + 26; m_by = 576; m_cnt = 0; m_score = 0;
      end else begin
        m_cnt++;
      end
    end
    m_px = np;
  endfunction

  task automatic tick(input bit l, input bit r, input bit go);
    @(negedge CLK);
    BTN_LEFT = l; BTN_RIGHT = r; BTN_LAUNCH = go;
    FRAME_DONE = 1'b1;
    model_step(l, r, go);
    q.push_back('{m_st, m_px, m_bx, m_by, m_score});
    @(negedge CLK);
    FRAME_DONE = 1'b0;
    BTN_LEFT = 1'b0; BTN_RIGHT = 1'b0; BTN_LAUNCH = 1'b0;
  endtask

  // monitor: frame ticks pop the scoreboard, other edges must hold
  initial begin
    exp_t e;
    bit fd;
    forever begin
      @(posedge CLK);
      fd = FRAME_DONE;
      #1;
      if (fd) begin
        if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL sb_underflow: got tick expected none at %0t", $time);
        end else begin
          e = q.pop_front();
          chk("tick_state", int'(STATE), e.st);
          chk("tick_paddle", int'(PADDLE_X_PIXEL), e.px);
          chk("tick_ball_x", int'(BALL_X_PIXEL), e.bx);
          chk("tick_ball_y", int'(BALL_Y_PIXEL), e.by);
`ifdef GAME_PHYSICS_SCORE_EN
          chk("tick_score", dut_score(), e.sc);
`endif
        end
      end else begin
        chk("hold_state", int'(STATE), m_st);
        chk("hold_paddle", int'(PADDLE_X_PIXEL), m_px);
        chk("hold_ball_x", int'(BALL_X_PIXEL), m_bx);
        chk("hold_ball_y", int'(BALL_Y_PIXEL), m_by);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard, off, tgt;
    bit l, r;
    model_reset();
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;
    chk("rst_state", int'(STATE), 0);
    chk("rst_paddle", int'(PADDLE_X_PIXEL), 370);
    chk("rst_ball_x", int'(BALL_X_PIXEL), 396);
    chk("rst_ball_y", int'(BALL_Y_PIXEL), 576);
`ifdef GAME_PHYSICS_SCORE_EN
    chk("rst_score", dut_score(), 0);
`endif

    repeat (3) tick(0, 0, 0);
    chk("idle_state", int'(STATE), 0);
    chk("idle_paddle", int'(PADDLE_X_PIXEL), 370);
    chk("idle_ball_x", int'(BALL_X_PIXEL), 396);
    tick(0, 0, 1);
    chk("launch_state", int'(STATE), 1);
    chk("launch_ball_x", int'(BALL_X_PIXEL), 396);
    chk("launch_ball_y", int'(BALL_Y_PIXEL), 576);
    tick(0, 0, 0);
    chk("play1_ball_x", int'(BALL_X_PIXEL), 398);
    chk("play1_ball_y", int'(BALL_Y_PIXEL), 574);
    repeat (5) tick(1, 0, 0);

    @(negedge CLK);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("arst_state", int'(STATE), 0);
    chk("arst_paddle", int'(PADDLE_X_PIXEL), 370);
    chk("arst_ball_x", int'(BALL_X_PIXEL), 396);
    chk("arst_ball_y", int'(BALL_Y_PIXEL), 576);
    model_reset();
    @(negedge CLK);
    RESET_N = 1'b1;

    BTN_LEFT = 1'b1;
    repeat (5) @(negedge CLK);
    BTN_LEFT = 1'b0;
    chk("nodone_paddle", int'(PADDLE_X_PIXEL), 370);

    repeat (100) tick(1, 0, 0);
    chk("left_paddle", int'(PADDLE_X_PIXEL), 8);
    chk("left_ball_x", int'(BALL_X_PIXEL), 34);
    repeat (200) tick(0, 1, 0);
    chk("right_paddle", int'(PADDLE_X_PIXEL), 732);
    chk("right_ball_x", int'(BALL_X_PIXEL), 758);
    repeat (5) tick(1, 1, 0);
    chk("both_paddle", int'(PADDLE_X_PIXEL), 732);
    chk("both_ball_x", int'(BALL_X_PIXEL), 758);

    tick(0, 0, 1);
    guard = 0;
    while (m_st == 1 && m_score < 3 && guard < 4000) begin
      off = (m_score == 0) ? -20 : (m_score == 1) ? 0 : 20;
      tgt = m_bx + 4 - off - 30;
      l = (m_px > tgt + 2);
      r = (m_px < tgt - 2);
      tick(l, r, 0);
      guard++;
    end
    guard = 0;
    while (m_st != 2 && guard < 4000) begin
      if (m_st == 0) tick(0, 0, 1);
      else if (m_bx + 4 < 400) tick(0, 1, 0);
      else tick(1, 0, 0);
      guard++;
    end
    chk("lost_state", int'(STATE), 2);
    chk("lost_ball_y", int'(BALL_Y_PIXEL), 600);
    repeat (59) tick(0, 0, 0);
    chk("lost59_state", int'(STATE), 2);
    tick(0, 0, 0);
    chk("reserve_state", int'(STATE), 0);
    chk("reserve_ball_y", int'(BALL_Y_PIXEL), 576);
    chk("reserve_ball_x", int'(BALL_X_PIXEL), m_px + 26);
`ifdef GAME_PHYSICS_SCORE_EN
    chk("reserve_score", dut_score(), 0);
`endif

    repeat (3) @(negedge CLK);
    chk("sb_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
